// File: rtl/adbg_wr_deser.sv
// Debug write-path deserializer: serial tdi -> words, trailing CRC check.
// Optional idle watchdog enabled by defining ADBG_WR_DESER_TIMEOUT_EN.
module adbg_wr_deser #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_word_count,
  input  logic              i_tdi,
  input  logic              i_shift_en,
  output logic [WORD_W-1:0] o_wr_data,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic              o_crc_data,
  output logic              o_crc_en,
  output logic              o_crc_clr,
  input  logic [31:0]       i_crc_in,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_crc_ok,
  output logic              o_overrun,
  output logic              o_timeout
);

  localparam int unsigned BW = $clog2(WORD_W);

  if (!(WORD_W == 8 || WORD_W == 16 || WORD_W == 32) || TIMEOUT < 2)
  begin : g_bad_param
    $error("adbg_wr_deser: illegal WORD_W or TIMEOUT");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DATA, S_CRC, S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_wcnt;
  logic [BW-1:0]      r_bcnt;
  logic [4:0]         r_ccnt;
  logic [WORD_W-2:0]  r_shift;
  logic [30:0]        r_crc_sh;
  logic [WORD_W-1:0]  r_wr_data;
  logic               r_wr_valid;
  logic               r_crc_ok;
  logic               r_overrun;
  logic               r_timeout;

  logic               w_word_end;
  logic               w_crc_end;
  logic               w_last_word;
  logic               w_to_hit;
  logic [WORD_W-1:0]  w_word;
  logic [31:0]        w_crc_rx;

  assign w_word_end  = i_shift_en && (r_state == S_DATA)
                    && (r_bcnt == BW'(WORD_W - 1));
  assign w_crc_end   = i_shift_en && (r_state == S_CRC)
                    && (r_ccnt == 5'd31);
  assign w_last_word = (r_wcnt + CNT_W'(1)) == r_cnt;
  assign w_word      = {i_tdi, r_shift};
  assign w_crc_rx    = {i_tdi, r_crc_sh};

`ifdef ADBG_WR_DESER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;

  assign w_to_hit = o_busy && !i_shift_en && !i_start
                 && (r_to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_start || !o_busy || i_shift_en)
      r_to_cnt <= '0;
    else
      r_to_cnt <= r_to_cnt + TW'(1);
  end
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_start)
      w_next = (i_word_count == '0) ? S_DONE : S_WAIT;
    else if (w_to_hit)
      w_next = S_DONE;
    else begin
      unique case (r_state)
        S_IDLE: w_next = S_IDLE;
        S_WAIT: if (i_shift_en && i_tdi) w_next = S_DATA;
        S_DATA: if (w_word_end && w_last_word) w_next = S_CRC;
        S_CRC:  if (w_crc_end) w_next = S_DONE;
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy   = 1'b0;
    o_done   = 1'b0;
    o_crc_en = 1'b0;
    unique case (r_state)
      S_WAIT, S_CRC: o_busy = 1'b1;
      S_DATA: begin
        o_busy   = 1'b1;
        o_crc_en = i_shift_en && !i_start && !i_rst;
      end
      S_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_crc_clr  = i_start && !i_rst;
  assign o_crc_data = i_tdi;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_wcnt     <= '0;
      r_bcnt     <= '0;
      r_ccnt     <= '0;
      r_shift    <= '0;
      r_crc_sh   <= '0;
      r_wr_data  <= '0;
      r_wr_valid <= 1'b0;
      r_crc_ok   <= 1'b0;
      r_overrun  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_wr_valid && i_wr_ready) r_wr_valid <= 1'b0;
      if (i_start) begin
        r_cnt     <= i_word_count;
        r_wcnt    <= '0;
        r_bcnt    <= '0;
        r_ccnt    <= '0;
        r_crc_ok  <= 1'b0;
        r_overrun <= 1'b0;
        r_timeout <= 1'b0;
      end else if (w_to_hit) begin
        r_timeout <= 1'b1;
      end else if (i_shift_en && r_state == S_DATA) begin
        if (w_word_end) begin
          r_bcnt <= '0;
          r_wcnt <= r_wcnt + CNT_W'(1);
          // a still-pending word wins; the new one is lost
          if (!r_wr_valid || i_wr_ready) begin
            r_wr_data  <= w_word;
            r_wr_valid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end else begin
          r_shift[r_bcnt] <= i_tdi;
          r_bcnt          <= r_bcnt + BW'(1);
        end
      end else if (i_shift_en && r_state == S_CRC) begin
        if (w_crc_end) begin
          r_crc_ok <= (w_crc_rx == i_crc_in);
        end else begin
          r_crc_sh[r_ccnt] <= i_tdi;
          r_ccnt           <= r_ccnt + 5'd1;
        end
      end
    end
  end

  assign o_wr_data  = r_wr_data;
  assign o_wr_valid = r_wr_valid;
  assign o_crc_ok   = r_crc_ok;
  assign o_overrun  = r_overrun;
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_adbg_wr_deser.sv
// Scoreboard bench for adbg_wr_deser: directed bursts, words and done
// pulses checked by a negedge monitor against queued expectations.
module tb_adbg_wr_deser;

  localparam int W  = 32;
  localparam int CW = 16;
  localparam logic [31:0] CRC_GOOD = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          i_rst, i_start, i_tdi, i_shift_en, i_wr_ready;
  logic [CW-1:0] i_word_count;
  logic [31:0]   i_crc_in;
  logic [W-1:0]  o_wr_data;
  logic          o_wr_valid, o_crc_data, o_crc_en, o_crc_clr;
  logic          o_busy, o_done, o_crc_ok, o_overrun, o_timeout;

  always #5 clk = ~clk;

  adbg_wr_deser #(.WORD_W(W), .CNT_W(CW), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
    .i_word_count(i_word_count), .i_tdi(i_tdi),
    .i_shift_en(i_shift_en), .o_wr_data(o_wr_data),
    .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready),
    .o_crc_data(o_crc_data), .o_crc_en(o_crc_en),
    .o_crc_clr(o_crc_clr), .i_crc_in(i_crc_in),
    .o_busy(o_busy), .o_done(o_done), .o_crc_ok(o_crc_ok),
    .o_overrun(o_overrun), .o_timeout(o_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int crc_en_cnt = 0;
  int base;
  logic [W-1:0] exp_words[$];
  logic         exp_done[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event with empty scoreboard", name);
  endtask

  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_crc_en) crc_en_cnt++;
      if (o_wr_valid && i_wr_ready) begin
        if (exp_words.size() == 0) fail_now("wr_word");
        else chk("wr_data", 64'(o_wr_data), 64'(exp_words.pop_front()));
      end
      if (o_done) begin
        if (exp_done.size() == 0) fail_now("done");
        else chk("done_crc_ok", 64'(o_crc_ok), 64'(exp_done.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(int n);
    i_start = 1'b1;
    i_word_count = CW'(n);
    tick();
    i_start = 1'b0;
  endtask

  task automatic sbit(logic b);
    i_shift_en = 1'b1;
    i_tdi = b;
    tick();
    i_shift_en = 1'b0;
    i_tdi = 1'b0;
  endtask

  task automatic sword(logic [W-1:0] w);
    for (int i = 0; i < W; i++) sbit(w[i]);
  endtask

  task automatic scrc(logic [31:0] c);
    for (int i = 0; i < 32; i++) sbit(c[i]);
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_tdi = 1'b0; i_shift_en = 1'b0;
    i_wr_ready = 1'b0; i_word_count = '0; i_crc_in = CRC_GOOD;
    repeat (3) tick();
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_wr_valid", 64'(o_wr_valid), 0);
    chk("rst_wr_data", 64'(o_wr_data), 0);
    chk("rst_done", 64'(o_done), 0);
    chk("rst_flags", {61'd0, o_crc_ok, o_overrun, o_timeout}, 0);
    chk("rst_crc_ctl", {62'd0, o_crc_clr, o_crc_en}, 0);
    i_rst = 1'b0;
    tick();

    // two-word burst, good CRC
    i_wr_ready = 1'b1;
    exp_words.push_back(32'h1234_5678);
    exp_words.push_back(32'hCAFE_F00D);
    exp_done.push_back(1'b1);
    base = crc_en_cnt;
    do_start(2);
    chk("a_busy", 64'(o_busy), 1);
    sbit(0); sbit(0); sbit(1);
    sword(32'h1234_5678);
    sword(32'hCAFE_F00D);
    scrc(CRC_GOOD);
    tick(); tick();
    chk("a_crc_ok", 64'(o_crc_ok), 1);
    chk("a_crc_en_cnt", 64'(crc_en_cnt - base), 64);
    chk("a_overrun", 64'(o_overrun), 0);
    chk("a_busy_end", 64'(o_busy), 0);

    // same burst, CRC bit 0 flipped
    exp_words.push_back(32'h1234_5678);
    exp_words.push_back(32'hCAFE_F00D);
    exp_done.push_back(1'b0);
    do_start(2);
    sbit(0); sbit(0); sbit(1);
    sword(32'h1234_5678);
    sword(32'hCAFE_F00D);
    scrc(CRC_GOOD ^ 32'h1);
    tick(); tick();
    chk("b_crc_ok", 64'(o_crc_ok), 0);

    // consumer stalled for a three-word burst
    i_wr_ready = 1'b0;
    exp_done.push_back(1'b1);
    do_start(3);
    sbit(1);
    sword(32'hA1A1_0001);
    sword(32'hB2B2_0002);
    sword(32'hC3C3_0003);
    scrc(CRC_GOOD);
    repeat (4) tick();
    chk("c_wr_valid", 64'(o_wr_valid), 1);
    chk("c_wr_data", 64'(o_wr_data), 64'h0000_0000_A1A1_0001);
    chk("c_overrun", 64'(o_overrun), 1);
    chk("c_crc_ok", 64'(o_crc_ok), 1);

    // reset at bit 17 with a word still pending
    do_start(2);
    chk("d_pending_kept", 64'(o_wr_valid), 1);
    sbit(1);
    for (int i = 0; i < 17; i++) sbit(1'(i % 3 == 0));
    i_rst = 1'b1;
    i_shift_en = 1'b1;
    i_tdi = 1'b1;
    tick();
    i_rst = 1'b0;
    i_shift_en = 1'b0;
    i_tdi = 1'b0;
    chk("d_busy", 64'(o_busy), 0);
    chk("d_wr_valid", 64'(o_wr_valid), 0);
    chk("d_wr_data", 64'(o_wr_data), 0);
    chk("d_flags", {60'd0, o_done, o_crc_ok, o_overrun, o_timeout}, 0);
    i_wr_ready = 1'b1;
    exp_words.push_back(32'h0BAD_F00D);
    exp_done.push_back(1'b1);
    do_start(1);
    sbit(1);
    sword(32'h0BAD_F00D);
    scrc(CRC_GOOD);
    tick(); tick();
    chk("d_crc_ok", 64'(o_crc_ok), 1);

    // zero-length burst
    exp_done.push_back(1'b0);
    base = crc_en_cnt;
    do_start(0);
    chk("e_done", 64'(o_done), 1);
    chk("e_busy", 64'(o_busy), 0);
    tick();
    chk("e_crc_ok", 64'(o_crc_ok), 0);
    chk("e_crc_en_cnt", 64'(crc_en_cnt - base), 0);

    // restart in the middle of a word
    do_start(1);
    sbit(1);
    for (int i = 0; i < 10; i++) sbit(1'(i % 2));
    i_start = 1'b1;
    i_word_count = CW'(2);
    i_shift_en = 1'b1;
    i_tdi = 1'b1;
    #1;
    chk("e_crc_clr", 64'(o_crc_clr), 1);
    chk("e_crc_en_prio", 64'(o_crc_en), 0);
    tick();
    i_start = 1'b0;
    i_shift_en = 1'b0;
    i_tdi = 1'b0;
    chk("e_restart_busy", 64'(o_busy), 1);
    base = crc_en_cnt;
    exp_words.push_back(32'h5555_AAAA);
    exp_words.push_back(32'h0000_0001);
    exp_done.push_back(1'b1);
    sbit(0); sbit(1);
    sword(32'h5555_AAAA);
    sword(32'h0000_0001);
    scrc(CRC_GOOD);
    tick(); tick();
    chk("e_restart_crc_ok", 64'(o_crc_ok), 1);
    chk("e_restart_crc_en", 64'(crc_en_cnt - base), 64);

    // watchdog: shifting stops mid-word
    do_start(1);
    sbit(1);
    for (int i = 0; i < 5; i++) sbit(1'b1);
`ifdef ADBG_WR_DESER_TIMEOUT_EN
    exp_done.push_back(1'b0);
    begin
      int k = 0;
      while (!o_done && k < 40) begin
        tick();
        k++;
      end
    end
    chk("f_done_seen", 64'(o_done), 1);
    chk("f_timeout", 64'(o_timeout), 1);
    tick();
    chk("f_busy", 64'(o_busy), 0);
    chk("f_crc_ok", 64'(o_crc_ok), 0);
`else
    repeat (40) tick();
    chk("f_busy_held", 64'(o_busy), 1);
    chk("f_timeout", 64'(o_timeout), 0);
`endif

    tick();
    chk("words_left", 64'(exp_words.size()), 0);
    chk("done_left", 64'(exp_done.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
